// File: rtl/mul1.sv
// mul1 -- first-order masked AND gadget (domain-oriented, 2 shares, 1 random bit).
//
// Ports:
//   clk  in   1  clock, all state updates on rising edge
//   rst  in   1  asynchronous active-high reset, clears all registers
//   x    in   2  first operand shares, unmasked value x[0]^x[1]
//   y    in   2  second operand shares, unmasked value y[0]^y[1]
//   r1   in   1  fresh uniform random mask bit, one per cycle
//   z    out  2  product shares, unmasked value z[0]^z[1]
//
// One-cycle latency, one operation per cycle, no stalls. z is driven only from
// registers, so there is no combinational path from x, y or r1 to z.
module mul1 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       r1,
    output logic [1:0] z
);

    // Inner-domain products: each uses only one share index, so no mask needed.
    (* keep = "true" *) logic p00;
    (* keep = "true" *) logic p11;
    // Cross-domain products: must be masked by r1 and registered before they
    // meet an inner-domain term, otherwise glitches could recombine shares.
    (* keep = "true" *) logic c01;
    (* keep = "true" *) logic c10;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p00 <= 1'b0;
            p11 <= 1'b0;
            c01 <= 1'b0;
            c10 <= 1'b0;
        end else begin
            p00 <= x[0] & y[0];
            p11 <= x[1] & y[1];
            c01 <= (x[0] & y[1]) ^ r1;
            c10 <= (x[1] & y[0]) ^ r1;
        end
    end

    // Both shares carry r1 once, so it cancels in z[0]^z[1].
    always_comb begin
        z[0] = p00 ^ c01;
        z[1] = p11 ^ c10;
    end

endmodule

// File: tb/tb_mul1.sv
// tb_mul1 -- self-checking bench for mul1 with a scoreboard of expected shares.
module tb_mul1;

    logic       clk;
    logic       rst;
    logic [1:0] x;
    logic [1:0] y;
    logic       r1;
    logic [1:0] z;

    int checks;
    int errors;

    logic [1:0] q[$];

    mul1 dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .r1  (r1),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output shares from the gadget algebra.
    function automatic logic [1:0] model(input logic [1:0] xv, input logic [1:0] yv,
                                         input logic rv);
        logic s0;
        logic s1;
        s0 = (xv[0] & yv[0]) ^ (xv[0] & yv[1]) ^ rv;
        s1 = (xv[1] & yv[1]) ^ (xv[1] & yv[0]) ^ rv;
        return {s1, s0};
    endfunction

    // Drive one operation at the falling edge and record its expected result.
    task automatic apply(input logic [1:0] xv, input logic [1:0] yv, input logic rv);
        @(negedge clk);
        x  = xv;
        y  = yv;
        r1 = rv;
        q.push_back(model(xv, yv, rv));
    endtask

    task automatic test_reset();
        x   = 2'b11;
        y   = 2'b01;
        r1  = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (z !== 2'b00) begin
            errors++;
            $display("FAIL reset_immediate z=%b expected=00", z);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x  = 2'(i);
            y  = 2'(3 - i);
            r1 = i[0];
            @(posedge clk);
            #1;
            checks++;
            if (z !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold[%0d] z=%b expected=00", i, z);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [1:0] xs[3];
        logic [1:0] ys[3];
        logic       rs[3];
        logic [1:0] lit[3];
        logic [1:0] e;
        xs = '{2'b01, 2'b01, 2'b11};
        ys = '{2'b10, 2'b10, 2'b11};
        rs = '{1'b0, 1'b1, 1'b0};
        lit = '{2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 3; i++) begin
            apply(xs[i], ys[i], rs[i]);
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if (z !== e || z !== lit[i]) begin
                errors++;
                $display("FAIL basic[%0d] z=%b expected=%b", i, z, lit[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] e;
        apply(2'b01, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if (z !== e) begin
            errors++;
            $display("FAIL mid_reset_pre z=%b expected=%b", z, e);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (z !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_async z=%b expected=00", z);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        for (int i = 0; i < 32; i++) begin
            apply(2'(i >> 3), 2'(i >> 1), i[0]);
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if (z !== e || (z[0] ^ z[1]) !== ((x[0] ^ x[1]) & (y[0] ^ y[1]))) begin
                errors++;
                $display("FAIL b2b[%0d] x=%b y=%b r1=%b z=%b expected=%b", i, x, y, r1, z, e);
            end
        end
    endtask

    task automatic test_random_reset();
        logic [1:0] e;
        for (int i = 0; i < 60; i++) begin
            apply(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if (z !== e) begin
                errors++;
                $display("FAIL rand[%0d] z=%b expected=%b", i, z, e);
            end
            if (i % 10 == 7) begin
                #1;
                rst = 1'b1;
                #1;
                checks++;
                if (z !== 2'b00) begin
                    errors++;
                    $display("FAIL rand_rst[%0d] z=%b expected=00", i, z);
                end
                #1;
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        x      = 2'b00;
        y      = 2'b00;
        r1     = 1'b0;
        rst    = 1'b1;
        test_reset();
        test_basic();
        test_mid_reset();
        test_back_to_back();
        test_random_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
